// File: rtl/hex_binary_serializer_if.sv
// Valid/ready bus between a hex line-vector source and the binary index consumer.
// Both handshakes and all result flags live here; clk/rst_n stay plain ports.
interface hex_binary_serializer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] hex;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] binary;
    logic             out_last;
    logic             multi_hot;
    logic             err_zero;

    // Source side: offers vectors and consumes indices.
    modport master (
        output in_valid, hex, out_ready,
        input  in_ready, out_valid, binary, out_last, multi_hot, err_zero
    );

    // Serializer side.
    modport slave (
        input  in_valid, hex, out_ready,
        output in_ready, out_valid, binary, out_last, multi_hot, err_zero
    );
endinterface

// File: rtl/hex_binary_serializer.sv
// Serializes a hex line vector into the binary indices of its set lines, lowest first,
// one index per accepted output beat.
module hex_binary_serializer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hex_binary_serializer_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]       state_q,     state_d;
    logic [WIDTH-1:0] pending_q,   pending_d;
    logic [IDX_W-1:0] binary_q,    binary_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q,  out_last_d;
    logic             multi_hot_q, multi_hot_d;
    logic             err_zero_q,  err_zero_d;
    logic             in_ready_q,  in_ready_d;

    // Priority scan: the last hit walking downward is the lowest set line.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Clears the lowest set bit.
    function automatic logic [WIDTH-1:0] drop_lowest(input logic [WIDTH-1:0] v);
        return v & (v - WIDTH'(1));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            binary_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            multi_hot_q <= 1'b0;
            err_zero_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            binary_q    <= binary_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            multi_hot_q <= multi_hot_d;
            err_zero_q  <= err_zero_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        binary_d    = binary_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        multi_hot_d = multi_hot_q;
        err_zero_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // in_ready_q gates acceptance so the first edge after reset cannot take a vector.
                if (bus.in_valid && in_ready_q) begin
                    if (bus.hex != '0) begin
                        binary_d    = lowest_set(bus.hex);
                        pending_d   = drop_lowest(bus.hex);
                        out_last_d  = (pending_d == '0);
                        multi_hot_d = (pending_d != '0);
                        out_valid_d = 1'b1;
                        state_d     = EMIT;
                    end else begin
                        err_zero_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (!out_last_q) begin
                        binary_d    = lowest_set(pending_q);
                        pending_d   = drop_lowest(pending_q);
                        out_last_d  = (pending_d == '0);
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        multi_hot_d = 1'b0;
                        pending_d   = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                multi_hot_d = 1'b0;
                pending_d   = '0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.binary    = binary_q;
    assign bus.out_last  = out_last_q;
    assign bus.multi_hot = multi_hot_q;
    assign bus.err_zero  = err_zero_q;

endmodule
